// File: rtl/denise_bpl_receiver_pkg.sv
// Shared constants, pixel-mode encoding and address helpers for the Denise bitplane receive path.
package denise_bpl_receiver_pkg;

    localparam int NPL_DEF   = 6;
    localparam int WORD_W    = 16;
    localparam int SCROLL_W  = 4;
    localparam int DLY_DEPTH = 16;

    localparam logic [8:0] RGA_BPL1DAT = 9'h110;
    localparam logic [8:0] RGA_BPLCON1 = 9'h102;

    typedef enum logic [1:0] {
        PM_LORES = 2'd0,
        PM_HIRES = 2'd1,
        PM_SHRES = 2'd2
    } pix_mode_t;

    // BPLnDAT byte address; the data registers sit on consecutive words after BPL1DAT.
    function automatic logic [8:0] bpldat_adr(input logic [8:0] base, input int n);
        return base + 9'(2 * (n - 1));
    endfunction

    function automatic pix_mode_t pix_mode(input logic shres, input logic hires);
        if (shres) return PM_SHRES;
        if (hires) return PM_HIRES;
        return PM_LORES;
    endfunction

endpackage

// File: rtl/denise_bpl_plane.sv
// One bitplane: 16-bit parallel-load serialiser, 16-tap scroll delay line and tap select.
// Tap output is combinational from registered state; load and shift are never stalled.
module denise_bpl_plane
    import denise_bpl_receiver_pkg::*;
(
    input  logic                clk,
    input  logic                _reset,
    input  logic                load,
    input  logic [WORD_W-1:0]   load_data,
    input  logic                shift_en,
    input  logic [SCROLL_W-1:0] scroll,
    output logic                out
);

    logic [WORD_W-1:0]    r_shift;
    logic [DLY_DEPTH-2:0] r_dly;
    logic [DLY_DEPTH-1:0] w_taps;

    // Tap 0 is the live MSB, tap k is the MSB as it was k shift steps ago.
    assign w_taps = {r_dly, r_shift[WORD_W-1]};
    assign out    = w_taps[scroll];

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_shift <= '0;
            r_dly   <= '0;
        end else begin
            if (load) begin
                r_shift <= load_data;
            end else if (shift_en) begin
                r_shift <= {r_shift[WORD_W-2:0], 1'b0};
            end
            if (shift_en) begin
                r_dly <= {r_dly[DLY_DEPTH-3:0], r_shift[WORD_W-1]};
            end
        end
    end

endmodule

// File: rtl/denise_bpl_receiver.sv
// Bitplane receiver: RGA decode, holding regs, pixel-rate shift enable, arming and output register.
// One shift step from load to first pixel at scroll 0; writes are never refused.
module denise_bpl_receiver
    import denise_bpl_receiver_pkg::*;
#(
    parameter int         NPL         = NPL_DEF,
    parameter logic [8:0] BPL1DAT_ADR = RGA_BPL1DAT,
    parameter logic [8:0] BPLCON1_ADR = RGA_BPLCON1
) (
    input  logic           clk,
    input  logic           _reset,
    input  logic           clk7_en,
    input  logic           hires,
    input  logic           shres,
    input  logic           blank,
    input  logic [8:1]     reg_address_in,
    input  logic [15:0]    data_in,
    output logic [NPL-1:0] bpldata,
    output logic           armed
);

    localparam logic [8:1] BPL1DAT_WA = BPL1DAT_ADR[8:1];
    localparam logic [8:1] BPLCON1_WA = BPLCON1_ADR[8:1];

    logic [1:0]          r_ph;
    logic [SCROLL_W-1:0] r_pf1_scroll;
    logic [SCROLL_W-1:0] r_pf2_scroll;
    logic                r_armed;
    logic [NPL-1:0]      r_bpldata;

    logic [1:0]          w_ph;
    pix_mode_t           w_mode;
    logic                w_shift_en;
    logic                w_wr_bpl1;
    logic                w_wr_con1;
    logic                w_armed_nxt;
    logic [NPL-1:0]      w_tap;
    logic [WORD_W-1:0]   w_load_dat [NPL];

    // The phase is forced to zero in the 7 MHz slot so the counter realigns itself.
    assign w_ph   = clk7_en ? 2'd0 : r_ph;
    assign w_mode = pix_mode(shres, hires);

    always_comb begin
        w_shift_en = clk7_en;
        case (w_mode)
            PM_SHRES: w_shift_en = 1'b1;
            PM_HIRES: w_shift_en = ~w_ph[0];
            default:  w_shift_en = clk7_en;
        endcase
    end

    assign w_wr_bpl1   = clk7_en && (reg_address_in == BPL1DAT_WA);
    assign w_wr_con1   = clk7_en && (reg_address_in == BPLCON1_WA);
    assign w_armed_nxt = blank ? 1'b0 : (w_wr_bpl1 ? 1'b1 : r_armed);

    // Plane 1 loads straight from the bus, so only planes 2..NPL need a holding register.
    assign w_load_dat[0] = data_in;

    for (genvar p = 1; p < NPL; p++) begin : g_hold
        localparam logic [8:0] ADR = bpldat_adr(BPL1DAT_ADR, p + 1);
        logic [WORD_W-1:0] r_hold;

        always_ff @(posedge clk or negedge _reset) begin
            if (!_reset) begin
                r_hold <= '0;
            end else if (clk7_en && (reg_address_in == ADR[8:1])) begin
                r_hold <= data_in;
            end
        end

        assign w_load_dat[p] = r_hold;
    end

    // Odd planes (even index) follow playfield 1 scroll, even planes playfield 2.
    for (genvar i = 0; i < NPL; i++) begin : g_plane
        denise_bpl_plane u_plane (
            .clk       (clk),
            ._reset    (_reset),
            .load      (w_wr_bpl1),
            .load_data (w_load_dat[i]),
            .shift_en  (w_shift_en),
            .scroll    ((i % 2 == 0) ? r_pf1_scroll : r_pf2_scroll),
            .out       (w_tap[i])
        );
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_ph         <= 2'd0;
            r_pf1_scroll <= '0;
            r_pf2_scroll <= '0;
            r_armed      <= 1'b0;
            r_bpldata    <= '0;
        end else begin
            r_ph <= w_ph + 2'd1;
            if (w_wr_con1) begin
                r_pf1_scroll <= data_in[3:0];
                r_pf2_scroll <= data_in[7:4];
            end
            r_armed <= w_armed_nxt;
            if (blank) begin
                r_bpldata <= '0;
            end else if (w_shift_en) begin
                r_bpldata <= w_tap & {NPL{w_armed_nxt}};
            end
        end
    end

    assign bpldata = r_bpldata;
    assign armed   = r_armed;

endmodule

// File: tb/tb_denise_bpl_receiver.sv
// Self-checking bench: directed pixel table, hires/shres/reset sequences, random traffic vs a pixel-stream model.
module tb_denise_bpl_receiver;

    localparam int NPL = 6;
    localparam logic [7:0] A_NOP = 8'h00;
    localparam logic [7:0] A_CON1 = 8'h81;
    localparam logic [7:0] A_BPL1 = 8'h88;
    localparam logic [7:0] A_BPL2 = 8'h89;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           clk7_en = 1'b0;
    logic           hires = 1'b0;
    logic           shres = 1'b0;
    logic           blank = 1'b0;
    logic [7:0]     reg_address_in = 8'h00;
    logic [15:0]    data_in = 16'h0000;
    logic [NPL-1:0] bpldata;
    logic           armed;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    denise_bpl_receiver dut (
        .clk            (clk),
        ._reset         (rst_n),
        .clk7_en        (clk7_en),
        .hires          (hires),
        .shres          (shres),
        .blank          (blank),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .bpldata        (bpldata),
        .armed          (armed)
    );

    always #5 clk = ~clk;

    // Reference model: each plane is "the last word loaded" plus how many pixels
    // have been emitted from it; the delay line is a log of past emitted pixels.
    logic [15:0] m_word [NPL];
    int          m_idx  [NPL];
    logic [15:0] m_hold [NPL];
    bit          m_log  [NPL][64];
    int          m_s;
    logic [3:0]  m_pf1, m_pf2;
    logic        m_armed;
    logic [NPL-1:0] m_bpl;
    int          m_since;

    task automatic model_reset();
        for (int p = 0; p < NPL; p++) begin
            m_word[p] = 16'h0;
            m_idx[p]  = 16;
            m_hold[p] = 16'h0;
            for (int j = 0; j < 64; j++) m_log[p][j] = 1'b0;
        end
        m_s = 0; m_pf1 = 4'h0; m_pf2 = 4'h0;
        m_armed = 1'b0; m_bpl = '0; m_since = 0;
    endtask

    task automatic model_edge();
        int ph;
        int k;
        logic sh, wr1, an;
        logic [NPL-1:0] msb, taps;
        ph = clk7_en ? 0 : m_since;
        m_since = (ph + 1) % 4;
        sh = shres ? 1'b1 : (hires ? (ph % 2 == 0) : clk7_en);
        for (int p = 0; p < NPL; p++) begin
            msb[p] = (m_idx[p] < 16) ? m_word[p][15 - m_idx[p]] : 1'b0;
            k = (p % 2 == 0) ? int'(m_pf1) : int'(m_pf2);
            taps[p] = (k == 0) ? msb[p] : m_log[p][(m_s - k) & 63];
        end
        wr1 = clk7_en && (reg_address_in == A_BPL1);
        an = blank ? 1'b0 : (wr1 ? 1'b1 : m_armed);
        if (blank) m_bpl = '0;
        else if (sh) m_bpl = taps & {NPL{an}};
        if (sh) begin
            for (int p = 0; p < NPL; p++) m_log[p][m_s & 63] = msb[p];
            m_s++;
        end
        for (int p = 0; p < NPL; p++) begin
            if (wr1) begin
                m_word[p] = (p == 0) ? data_in : m_hold[p];
                m_idx[p]  = 0;
            end else if (sh && m_idx[p] < 16) begin
                m_idx[p]++;
            end
        end
        if (clk7_en) begin
            if (reg_address_in > A_BPL1 && reg_address_in < A_BPL1 + 8'(NPL))
                m_hold[reg_address_in - A_BPL1] = data_in;
            if (reg_address_in == A_CON1) begin
                m_pf1 = data_in[3:0];
                m_pf2 = data_in[7:4];
            end
        end
        m_armed = an;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        clk7_en = (cyc % 4 == 0);
        reg_address_in = a;
        data_in = d;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        cyc++;
        #1;
        check("model_bpldata", 32'(bpldata), 32'(m_bpl));
        check("model_armed", 32'(armed), 32'(m_armed));
    endtask

    task automatic align();
        while (cyc % 4 != 0) tick(A_NOP, 16'h0);
    endtask

    typedef struct {
        logic [7:0]     a;
        logic [15:0]    d;
        logic           blk;
        logic [NPL-1:0] exp_bpl;
        logic           exp_arm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] a, input logic [15:0] d, input logic blk,
                       input logic [NPL-1:0] e, input logic arm, input int n);
        vec_t v;
        v.a = a; v.d = d; v.blk = blk; v.exp_bpl = e; v.exp_arm = arm;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // One record = one lores pixel (4 clk); the write goes out in its 7 MHz slot.
        add(A_BPL2, 16'hFFFF, 0, 6'h00, 0, 1);
        add(A_BPL1, 16'h8001, 0, 6'h00, 1, 1);
        add(A_NOP,  16'h0,    0, 6'h03, 1, 1);
        add(A_NOP,  16'h0,    0, 6'h02, 1, 14);
        add(A_NOP,  16'h0,    0, 6'h03, 1, 1);
        add(A_NOP,  16'h0,    0, 6'h00, 1, 4);
        add(A_CON1, 16'h0030, 0, 6'h00, 1, 1);
        add(A_BPL2, 16'h8000, 0, 6'h00, 1, 1);
        add(A_BPL1, 16'h8000, 0, 6'h00, 1, 1);
        add(A_NOP,  16'h0,    0, 6'h01, 1, 1);
        add(A_NOP,  16'h0,    0, 6'h00, 1, 2);
        add(A_NOP,  16'h0,    0, 6'h02, 1, 1);
        add(A_NOP,  16'h0,    0, 6'h00, 1, 1);
        add(A_CON1, 16'h0000, 0, 6'h00, 1, 1);
        add(A_BPL2, 16'h0000, 0, 6'h00, 1, 1);
        add(A_BPL1, 16'hFFFF, 0, 6'h00, 1, 1);
        add(A_NOP,  16'h0,    0, 6'h01, 1, 4);
        add(A_NOP,  16'h0,    1, 6'h00, 0, 1);
        add(A_NOP,  16'h0,    0, 6'h00, 0, 2);
        add(A_BPL1, 16'h8000, 0, 6'h01, 1, 1);
        add(A_NOP,  16'h0,    0, 6'h01, 1, 1);
        add(A_NOP,  16'h0,    0, 6'h00, 1, 1);
        add(A_BPL1, 16'h8000, 1, 6'h00, 0, 1);
        add(A_NOP,  16'h0,    0, 6'h00, 0, 1);
        add(A_BPL1, 16'hFFFF, 0, 6'h00, 1, 1);
        add(A_NOP,  16'h0,    0, 6'h01, 1, 7);
        add(A_BPL1, 16'hF000, 0, 6'h01, 1, 1);
        add(A_NOP,  16'h0,    0, 6'h01, 1, 4);
        add(A_NOP,  16'h0,    0, 6'h00, 1, 2);

        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check("reset_bpldata", 32'(bpldata), 32'h0);
        check("reset_armed", 32'(armed), 32'h0);
        tick(A_NOP, 16'h0);
        tick(A_NOP, 16'h0);
        rst_n = 1'b1;
        cyc = 0;

        foreach (tbl[r]) begin
            blank = tbl[r].blk;
            tick(tbl[r].a, tbl[r].d);
            for (int j = 0; j < 3; j++) tick(A_NOP, 16'h0);
            check($sformatf("tbl%0d_bpldata", r), 32'(bpldata), 32'(tbl[r].exp_bpl));
            check($sformatf("tbl%0d_armed", r), 32'(armed), 32'(tbl[r].exp_arm));
        end
        blank = 1'b0;
        align();

        hires = 1'b1;
        tick(A_BPL1, 16'hAAAA);
        for (int k = 0; k < 16; k++) begin
            tick(A_NOP, 16'h0);
            tick(A_NOP, 16'h0);
            check($sformatf("hires_pix%0d", k), 32'(bpldata), (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        tick(A_NOP, 16'h0);
        tick(A_NOP, 16'h0);
        check("hires_drained", 32'(bpldata), 32'h0);
        align();

        shres = 1'b1;
        tick(A_BPL1, 16'hAAAA);
        for (int k = 0; k < 16; k++) begin
            tick(A_NOP, 16'h0);
            check($sformatf("shres_pix%0d", k), 32'(bpldata), (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        tick(A_NOP, 16'h0);
        check("shres_drained", 32'(bpldata), 32'h0);
        align();

        hires = 1'b0;
        shres = 1'b0;
        tick(A_BPL1, 16'hFFFF);
        for (int j = 0; j < 4; j++) tick(A_NOP, 16'h0);
        check("pre_reset_bpldata", 32'(bpldata), 32'h1);
        check("pre_reset_armed", 32'(armed), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_bpldata", 32'(bpldata), 32'h0);
        check("async_reset_armed", 32'(armed), 32'h0);
        tick(A_NOP, 16'h0);
        tick(A_NOP, 16'h0);
        rst_n = 1'b1;
        cyc = 0;

        for (int n = 0; n < 4000; n++) begin
            logic [7:0] a;
            if ($urandom_range(0, 99) == 0) {shres, hires} = 2'($urandom_range(0, 3));
            if (blank) begin
                if ($urandom_range(0, 14) == 0) blank = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                blank = 1'b1;
            end
            a = ($urandom_range(0, 3) == 0) ? A_BPL1 : 8'($urandom_range(8'h80, 8'h8F));
            tick(a, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/denise_bpl_receiver.md
Name: denise_bpl_receiver

Overview:
- Consumer end of the bitplane DMA path: captures BPLxDAT words driven onto the RGA bus by bitplane DMA, parallel-loads them into per-plane shifters on the BPL1DAT write, and serialises them into per-pixel plane bits.
- Applies BPLCON1 playfield scroll delays: odd planes use PF1, even planes use PF2.
- Sits in Denise between the RGA bus and the playfield/colour lookup logic.

Parameters:
- NPL, 6, number of bitplanes.
- BPL1DAT_ADR, 9'h110, RGA byte address of BPL1DAT. BPLnDAT = BPL1DAT_ADR + 2*(n-1).
- BPLCON1_ADR, 9'h102, RGA byte address of BPLCON1.

Ports:
- clk  in  1  28 MHz system clock.
- _reset  in  1  asynchronous, active-low reset.
- clk7_en  in  1  7 MHz enable, one clk cycle in four.
- hires  in  1  hires mode, 14 MHz pixels.
- shres  in  1  superhires mode, 28 MHz pixels; takes priority over hires.
- blank  in  1  horizontal/vertical blank; disarms output.
- reg_address_in  in  8 [8:1]  RGA word address.
- data_in  in  16  RGA write data.
- bpldata  out  NPL  current pixel plane bits; bit0 = plane 1.
- armed  out  1  high once a BPL1DAT load has occurred since the last blank.

Behaviour:
- Reset (_reset low, asynchronous): clear holding regs, shifters, delay lines, scroll regs, phase counter, armed, and bpldata.
- Register writes: accepted only in clk7_en cycles.
  - reg_address_in == BPLnDAT[8:1] writes holding[n].
  - reg_address_in == BPLCON1[8:1] writes pf1_scroll = data_in[3:0] and pf2_scroll = data_in[7:4].
  - All other addresses are ignored.
- Load: a BPL1DAT write copies all NPL holding regs into the shifters on the same edge.
  - holding[1] takes the new data_in, bypassing the holding register.
  - Sets armed on that edge.
  - Holding regs for planes 2..NPL keep their values, so an unrewritten plane is reused.
- Phase counter ph (2 bits): 0 in clk7_en cycles, otherwise increments; wraps 3->0.
- shift_en:
  - shres: every cycle.
  - hires: ph[0]==0.
  - lores: clk7_en.
- Shifters: on shift_en, shift left one bit and fill the LSB with 0. Load beats shift on the same edge. After 16 shifts without a reload, the shifter outputs 0.
- Delay lines:
  - Each plane has a 16-deep shift register clocked by shift_en, input = shifter MSB.
  - Tap 0 = shifter MSB (undelayed).
  - Tap k = MSB delayed by k shift_en steps.
  - Odd planes select tap pf1_scroll; even planes select tap pf2_scroll.
  - Scroll is in current-mode pixels. A scroll change takes effect on the next shift_en.
- bpldata register:
  - Updated only on shift_en: bpldata[i] = selected tap[i] & armed_next.
  - Latency at scroll 0: the first MSB appears on bpldata at the first shift_en edge after the load edge. In lores that is 4 clk cycles later.
- blank:
  - While blank is high, armed is cleared and bpldata is forced to 0 on the next edge.
  - Shifters and delay lines keep running.
  - A BPL1DAT write while blank is high still loads but does not set armed.
- Simultaneous BPL1DAT write and BPLCON1 write cannot occur (single RGA address per cycle).
- Mode change mid-line: the new shift_en rate applies from the next cycle; no flush.
- No back-pressure: writes are never refused.

Decomposition:
- Shared package:
  - RGA address constants BPL1DAT..BPL6DAT and BPLCON1.
  - Scroll width (4).
  - Delay depth (16).
  - Pixel-mode encoding.
- One natural sub-module: denise_bpl_plane, instantiated NPL times. It contains:
  - the 16-bit shifter;
  - the 16-deep delay line;
  - the tap mux.
  - Ports: clk, _reset, load, load_data, shift_en, scroll, out.
- Top level: address decode, holding regs, phase counter, armed/blank logic, and the output register.

Test Plan:
1. Reset: hold _reset low mid-stream -> bpldata=0 and armed=0 immediately (async), with no clock edge needed.
2. Lores, scroll 0: write BPL2DAT=16'hFFFF, then BPL1DAT=16'h8001 -> armed=1. Over the next 16 lores pixels, bpldata = 6'b000011 (pixel 0), then 6'b000010 (pixels 1-14), then 6'b000011 (pixel 15), then 0. First pixel appears 4 clk after the load edge.
3. Scroll: BPLCON1=16'h0030 (pf1=0, pf2=3), BPL2DAT=16'h8000, BPL1DAT=16'h8000 -> bpldata[0] is high at pixel 0 and bpldata[1] is high at pixel 3; each pulse lasts exactly one shift step.
4. Hires/shres: hires=1, BPL1DAT=16'hAAAA -> bpldata[0] toggles every 2 clk for 16 pixels. With shres=1, it toggles every clk.
5. Blank: raise blank mid-word -> bpldata=0 the next edge and armed=0. Drop blank -> bpldata stays 0 until the next BPL1DAT write, then resumes.
6. Reload before empty: issue BPL1DAT=16'hFFFF, then another BPL1DAT=16'hF000 8 pixels later -> the output is contiguous: 8 ones, then 4 ones, then zeros, with no gap or duplicate pixel.
